// File: rtl/flash_qspi_rd_seq_if.sv
// rtl/flash_qspi_rd_seq_if.sv - word read request/response channel between the bus-side flash slave and the QSPI read sequencer
interface flash_qspi_rd_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  resp_valid,
    input  resp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output resp_valid,
    output resp_data
  );
endinterface

// File: rtl/flash_qspi_rd_seq.sv
// rtl/flash_qspi_rd_seq.sv - Quad I/O Read (EBh) word sequencer that streams sequential words while chip-select stays low
module flash_qspi_rd_seq #(
  parameter int DUMMY       = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int CSH_CYCLES  = 4
) (
  input  logic               HCLK,
  input  logic               HRESET,
  flash_qspi_rd_seq_if.slave bus,
  output logic               fsclk,
  output logic               fcen,
  output logic [3:0]         fdo,
  output logic               fdoe,
  input  logic [3:0]         fdi
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_MODE, ST_DUMMY, ST_DATA, ST_HOLD, ST_CSH
  } state_t;

  localparam logic [7:0] CMD_QIO_READ = 8'hEB;

  state_t      state_q, state_d;
  logic        fsclk_q, fsclk_d;
  logic        fcen_q, fcen_d;
  logic        fdoe_q, fdoe_d;
  logic [3:0]  fdo_q, fdo_d;
  logic        lead_q, lead_d;
  logic [3:0]  sck_cnt_q, sck_cnt_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        go_cmd_q, go_cmd_d;
  logic [23:0] addr_q, addr_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_valid_q, resp_valid_d;
  logic        req_ready_q, req_ready_d;

  logic        accept;
  logic        last_sck;
  logic [23:0] req_word;
  logic [23:0] seq_addr;
  logic [4:0]  nib_pos;
  logic [4:0]  nib_lsb;

  assign accept   = bus.req_valid & req_ready_q;
  assign req_word = bus.req_addr & 24'hFFFFFC;
  assign seq_addr = addr_q + 24'd4;

  always_comb begin
    state_d      = state_q;
    fsclk_d      = fsclk_q;
    fcen_d       = fcen_q;
    lead_d       = lead_q;
    sck_cnt_d    = sck_cnt_q;
    cnt_d        = cnt_q;
    go_cmd_d     = go_cmd_q;
    addr_d       = addr_q;
    shift_d      = shift_q;
    resp_data_d  = resp_data_q;
    resp_valid_d = 1'b0;
    last_sck     = 1'b0;
    // Byte k/2 lands in bits [8*(k/2)+:8]; even samples are the high nibble.
    nib_pos      = {sck_cnt_q[2:1], ~sck_cnt_q[0], 2'b00};

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d    = req_word;
          state_d   = ST_CMD;
          fcen_d    = 1'b0;
          lead_d    = 1'b1;
          sck_cnt_d = 4'd0;
        end
      end

      ST_CMD, ST_ADDR, ST_MODE, ST_DUMMY, ST_DATA: begin
        case (state_q)
          ST_CMD:   last_sck = (sck_cnt_q == 4'd7);
          ST_ADDR:  last_sck = (sck_cnt_q == 4'd5);
          ST_MODE:  last_sck = (sck_cnt_q == 4'd1);
          ST_DUMMY: last_sck = (sck_cnt_q == 4'(DUMMY - 1));
          default:  last_sck = (sck_cnt_q == 4'd7);
        endcase
        // The first cycle after chip-select falls is an extra low phase for setup.
        if (lead_q) begin
          lead_d = 1'b0;
        end else if (!fsclk_q) begin
          fsclk_d = 1'b1;
        end else begin
          fsclk_d   = 1'b0;
          sck_cnt_d = last_sck ? 4'd0 : sck_cnt_q + 4'd1;
          if (state_q == ST_DATA) begin
            shift_d[nib_pos +: 4] = fdi;
          end
          if (last_sck) begin
            case (state_q)
              ST_CMD:   state_d = ST_ADDR;
              ST_ADDR:  state_d = ST_MODE;
              ST_MODE:  state_d = ST_DUMMY;
              ST_DUMMY: state_d = ST_DATA;
              default: begin
                state_d      = ST_HOLD;
                cnt_d        = 8'd0;
                resp_valid_d = 1'b1;
                resp_data_d  = shift_d;
              end
            endcase
          end
        end
      end

      ST_HOLD: begin
        if (accept) begin
          // A zero continuation address means the flash would wrap; restart instead.
          if (req_word == seq_addr && seq_addr != 24'd0) begin
            addr_d    = seq_addr;
            state_d   = ST_DATA;
            sck_cnt_d = 4'd0;
          end else begin
            addr_d   = req_word;
            state_d  = ST_CSH;
            fcen_d   = 1'b1;
            cnt_d    = 8'd0;
            go_cmd_d = 1'b1;
          end
        end else if (cnt_q == 8'(HOLD_CYCLES - 1)) begin
          state_d  = ST_CSH;
          fcen_d   = 1'b1;
          cnt_d    = 8'd0;
          go_cmd_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_CSH: begin
        if (cnt_q == 8'(CSH_CYCLES - 1)) begin
          cnt_d = 8'd0;
          if (go_cmd_q) begin
            state_d   = ST_CMD;
            fcen_d    = 1'b0;
            lead_d    = 1'b1;
            sck_cnt_d = 4'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase

    req_ready_d = (state_d == ST_IDLE) || (state_d == ST_HOLD);

    // Pin drive follows the phase and SCK index being entered, so it only moves on low phases.
    nib_lsb = 5'd20 - {sck_cnt_d[2:0], 2'b00};
    fdoe_d  = 1'b0;
    fdo_d   = 4'h0;
    case (state_d)
      ST_CMD: begin
        fdoe_d = 1'b1;
        fdo_d  = {3'b111, CMD_QIO_READ[~sck_cnt_d[2:0]]};
      end
      ST_ADDR: begin
        fdoe_d = 1'b1;
        fdo_d  = 4'(addr_d >> nib_lsb);
      end
      ST_MODE: begin
        fdoe_d = 1'b1;
        fdo_d  = 4'h0;
      end
      default: begin
        fdoe_d = 1'b0;
        fdo_d  = 4'h0;
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q      <= ST_IDLE;
      fsclk_q      <= 1'b0;
      fcen_q       <= 1'b1;
      fdoe_q       <= 1'b0;
      fdo_q        <= 4'h0;
      lead_q       <= 1'b0;
      sck_cnt_q    <= 4'd0;
      cnt_q        <= 8'd0;
      go_cmd_q     <= 1'b0;
      addr_q       <= 24'd0;
      shift_q      <= 32'd0;
      resp_data_q  <= 32'd0;
      resp_valid_q <= 1'b0;
      req_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      fsclk_q      <= fsclk_d;
      fcen_q       <= fcen_d;
      fdoe_q       <= fdoe_d;
      fdo_q        <= fdo_d;
      lead_q       <= lead_d;
      sck_cnt_q    <= sck_cnt_d;
      cnt_q        <= cnt_d;
      go_cmd_q     <= go_cmd_d;
      addr_q       <= addr_d;
      shift_q      <= shift_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
      req_ready_q  <= req_ready_d;
    end
  end

  assign fsclk          = fsclk_q;
  assign fcen           = fcen_q;
  assign fdo            = fdo_q;
  assign fdoe           = fdoe_q;
  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;

endmodule

// File: tb/tb_flash_qspi_rd_seq.sv
// tb/tb_flash_qspi_rd_seq.sv - self-checking bench with a behavioural SST26-style flash and a spec-level latency/data model
module tb_flash_qspi_rd_seq;
  localparam int DUMMY       = 4;
  localparam int HOLD_CYCLES = 16;
  localparam int CSH_CYCLES  = 4;
  localparam int FRESH_LAT   = 2 + 2 * (24 + DUMMY);
  localparam int SEQ_LAT     = 2 * 8 + 1;
  localparam int NONSEQ_LAT  = CSH_CYCLES + FRESH_LAT;
  localparam int SCK_FRESH   = 8 + 6 + 2 + DUMMY + 8;

  logic       HCLK = 1'b0;
  logic       HRESET = 1'b1;
  logic       fsclk, fcen, fdoe;
  logic [3:0] fdo;
  logic [3:0] fdi;

  flash_qspi_rd_seq_if bus ();

  flash_qspi_rd_seq #(
    .DUMMY(DUMMY), .HOLD_CYCLES(HOLD_CYCLES), .CSH_CYCLES(CSH_CYCLES)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus.slave),
    .fsclk(fsclk), .fcen(fcen), .fdo(fdo), .fdoe(fdoe), .fdi(fdi)
  );

  always #5 HCLK = ~HCLK;

  int n_cmp = 0;
  int n_fail = 0;

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    return a[7:0] ^ a[23:16];
  endfunction

  function automatic logic [31:0] exp_word(input logic [23:0] a);
    logic [23:0] w;
    w = a & 24'hFFFFFC;
    return {mem_byte(w + 24'd3), mem_byte(w + 24'd2), mem_byte(w + 24'd1), mem_byte(w)};
  endfunction

  // Flash: counts SCK rises per chip-select window and auto-increments through memory.
  int          rises = 0;
  int          txn_count = 0;
  logic [7:0]  f_cmd = 8'h00;
  logic [23:0] f_addr = 24'h0;
  always @(posedge fsclk or posedge fcen) begin
    if (fcen === 1'b1) begin
      rises = 0;
      txn_count++;
      fdi = 4'h0;
    end else begin
      int n;
      logic [7:0] b;
      rises++;
      if (rises <= 8) f_cmd = {f_cmd[6:0], fdo[0]};
      else if (rises <= 14) f_addr = {f_addr[19:0], fdo};
      else if (rises > 16 + DUMMY) begin
        n = rises - 17 - DUMMY;
        b = mem_byte(f_addr + 24'(n / 2));
        fdi = (n % 2 == 0) ? b[7:4] : b[3:0];
      end
      if (rises == 1) f_addr = 24'h0;
    end
  end

  // Pin rules and chip-select high-time monitor.
  logic mon_en = 1'b0;
  logic prev_fcen = 1'b1;
  logic prev_fsclk = 1'b0;
  int   pin_err = 0;
  int   hi_run = 0;
  int   last_hi_run = 0;
  int   resp_cnt = 0;
  always @(negedge HCLK) begin
    if (mon_en) begin
      if (fcen && fsclk) pin_err++;
      if ((fcen !== prev_fcen) && (fsclk || prev_fsclk)) pin_err++;
    end
    if (fcen) hi_run++;
    else begin
      if (hi_run > 0) last_hi_run = hi_run;
      hi_run = 0;
    end
    if (bus.resp_valid) resp_cnt++;
    prev_fcen  = fcen;
    prev_fsclk = fsclk;
  end

  // Called at a negedge; returns at the negedge of the resp_valid cycle.
  task automatic issue(input logic [23:0] addr, output int lat, output logic [31:0] data);
    int n;
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 200) begin
      @(negedge HCLK);
      n++;
    end
    if (n >= 200) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout addr=%h got=no_ready exp=ready", addr);
    end
    @(negedge HCLK);
    bus.req_valid = 1'b0;
    lat = 1;
    while (bus.resp_valid !== 1'b1 && lat < 300) begin
      @(negedge HCLK);
      lat++;
    end
    data = bus.resp_data;
  endtask

  task automatic wait_idle();
    repeat (HOLD_CYCLES + CSH_CYCLES + 6) @(negedge HCLK);
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = 24'h0;
    repeat (3) @(negedge HCLK);
    n_cmp++; if (fcen !== 1'b1) begin n_fail++; $display("FAIL reset_fcen got=%b exp=1", fcen); end
    n_cmp++; if (fsclk !== 1'b0) begin n_fail++; $display("FAIL reset_fsclk got=%b exp=0", fsclk); end
    n_cmp++; if (fdoe !== 1'b0) begin n_fail++; $display("FAIL reset_fdoe got=%b exp=0", fdoe); end
    n_cmp++; if (fdo !== 4'h0) begin n_fail++; $display("FAIL reset_fdo got=%h exp=0", fdo); end
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", bus.req_ready); end
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got=%b exp=0", bus.resp_valid); end
    n_cmp++; if (bus.resp_data !== 32'h0) begin n_fail++; $display("FAIL reset_resp_data got=%h exp=0", bus.resp_data); end
    HRESET = 1'b0;
    @(negedge HCLK);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset got=%b exp=1", bus.req_ready); end
    mon_en = 1'b1;
  endtask

  task automatic test_single_read();
    int lat; logic [31:0] d;
    issue(24'h000010, lat, d);
    n_cmp++; if (d !== exp_word(24'h10)) begin n_fail++; $display("FAIL single_data got=%h exp=%h", d, exp_word(24'h10)); end
    n_cmp++; if (d !== 32'h13121110) begin n_fail++; $display("FAIL single_data_const got=%h exp=13121110", d); end
    n_cmp++; if (lat !== FRESH_LAT) begin n_fail++; $display("FAIL single_lat got=%0d exp=%0d", lat, FRESH_LAT); end
    n_cmp++; if (rises !== SCK_FRESH) begin n_fail++; $display("FAIL single_sck_rises got=%0d exp=%0d", rises, SCK_FRESH); end
    n_cmp++; if (f_cmd !== 8'hEB) begin n_fail++; $display("FAIL single_cmd got=%h exp=eb", f_cmd); end
    n_cmp++; if (f_addr !== 24'h000010) begin n_fail++; $display("FAIL single_addr got=%h exp=000010", f_addr); end
  endtask

  task automatic test_hold_timeout();
    int k; int lat; logic [31:0] d;
    k = 0;
    while (fcen !== 1'b1 && k < 100) begin
      @(negedge HCLK);
      k++;
    end
    n_cmp++; if (k !== HOLD_CYCLES) begin n_fail++; $display("FAIL hold_timeout_cycles got=%0d exp=%0d", k, HOLD_CYCLES); end
    repeat (20) @(negedge HCLK);
    issue(24'h000014, lat, d);
    n_cmp++; if (lat !== FRESH_LAT) begin n_fail++; $display("FAIL after_timeout_lat got=%0d exp=%0d", lat, FRESH_LAT); end
    n_cmp++; if (d !== exp_word(24'h14)) begin n_fail++; $display("FAIL after_timeout_data got=%h exp=%h", d, exp_word(24'h14)); end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] d; int t0;
    issue(24'h000010, lat, d);
    n_cmp++; if (d !== exp_word(24'h10)) begin n_fail++; $display("FAIL b2b_data0 got=%h exp=%h", d, exp_word(24'h10)); end
    t0 = txn_count;
    issue(24'h000014, lat, d);
    n_cmp++; if (lat !== SEQ_LAT) begin n_fail++; $display("FAIL b2b_lat1 got=%0d exp=%0d", lat, SEQ_LAT); end
    n_cmp++; if (d !== 32'h17161514) begin n_fail++; $display("FAIL b2b_data1 got=%h exp=17161514", d); end
    issue(24'h000018, lat, d);
    n_cmp++; if (lat !== SEQ_LAT) begin n_fail++; $display("FAIL b2b_lat2 got=%0d exp=%0d", lat, SEQ_LAT); end
    n_cmp++; if (d !== 32'h1B1A1918) begin n_fail++; $display("FAIL b2b_data2 got=%h exp=1b1a1918", d); end
    n_cmp++; if (txn_count !== t0) begin n_fail++; $display("FAIL b2b_fcen_low got=%0d exp=%0d", txn_count, t0); end
    n_cmp++; if (rises !== SCK_FRESH + 16) begin n_fail++; $display("FAIL b2b_sck_rises got=%0d exp=%0d", rises, SCK_FRESH + 16); end
    wait_idle();
  endtask

  task automatic test_nonseq();
    int lat; logic [31:0] d; int t0;
    issue(24'h000010, lat, d);
    t0 = txn_count;
    issue(24'h000040, lat, d);
    n_cmp++; if (lat !== NONSEQ_LAT) begin n_fail++; $display("FAIL nonseq_lat got=%0d exp=%0d", lat, NONSEQ_LAT); end
    n_cmp++; if (d !== 32'h43424140) begin n_fail++; $display("FAIL nonseq_data got=%h exp=43424140", d); end
    n_cmp++; if (last_hi_run !== CSH_CYCLES) begin n_fail++; $display("FAIL nonseq_csh got=%0d exp=%0d", last_hi_run, CSH_CYCLES); end
    n_cmp++; if (txn_count !== t0 + 1) begin n_fail++; $display("FAIL nonseq_txn got=%0d exp=%0d", txn_count, t0 + 1); end
    n_cmp++; if (f_cmd !== 8'hEB) begin n_fail++; $display("FAIL nonseq_cmd got=%h exp=eb", f_cmd); end
    n_cmp++; if (f_addr !== 24'h000040) begin n_fail++; $display("FAIL nonseq_addr got=%h exp=000040", f_addr); end
    wait_idle();
  endtask

  task automatic test_wrap();
    int lat; logic [31:0] d;
    issue(24'hFFFFFC, lat, d);
    n_cmp++; if (d !== 32'h00010203) begin n_fail++; $display("FAIL wrap_data0 got=%h exp=00010203", d); end
    issue(24'h000000, lat, d);
    n_cmp++; if (lat !== NONSEQ_LAT) begin n_fail++; $display("FAIL wrap_lat got=%0d exp=%0d", lat, NONSEQ_LAT); end
    n_cmp++; if (d !== 32'h03020100) begin n_fail++; $display("FAIL wrap_data1 got=%h exp=03020100", d); end
    n_cmp++; if (f_addr !== 24'h000000) begin n_fail++; $display("FAIL wrap_addr got=%h exp=000000", f_addr); end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] d; int r0; int n;
    r0 = resp_cnt;
    bus.req_valid = 1'b1;
    bus.req_addr  = 24'h000010;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 200) begin @(negedge HCLK); n++; end
    @(negedge HCLK);
    bus.req_valid = 1'b0;
    repeat (20) @(negedge HCLK);
    while (fsclk !== 1'b0) @(negedge HCLK);
    n_cmp++; if (rises < 8 || rises >= 14) begin n_fail++; $display("FAIL reset_mid_in_addr got=%0d exp=8..13", rises); end
    HRESET = 1'b1;
    @(negedge HCLK);
    n_cmp++; if (fcen !== 1'b1) begin n_fail++; $display("FAIL reset_mid_fcen got=%b exp=1", fcen); end
    n_cmp++; if (fdoe !== 1'b0) begin n_fail++; $display("FAIL reset_mid_fdoe got=%b exp=0", fdoe); end
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid_resp got=%b exp=0", bus.resp_valid); end
    HRESET = 1'b0;
    repeat (80) @(negedge HCLK);
    n_cmp++; if (resp_cnt !== r0) begin n_fail++; $display("FAIL reset_mid_dropped got=%0d exp=%0d", resp_cnt, r0); end
    issue(24'h000010, lat, d);
    n_cmp++; if (d !== 32'h13121110) begin n_fail++; $display("FAIL reset_mid_reread got=%h exp=13121110", d); end
    n_cmp++; if (lat !== FRESH_LAT) begin n_fail++; $display("FAIL reset_mid_lat got=%0d exp=%0d", lat, FRESH_LAT); end
    wait_idle();
  endtask

  task automatic test_random();
    int lat; int gap; int exp_lat;
    logic [31:0] d; logic [31:0] r;
    logic [23:0] w; logic [23:0] prev; logic [23:0] nxt;
    prev = 24'h0;
    for (int i = 0; i < 16; i++) begin
      gap = (i == 0) ? 0 : (($urandom_range(0, 1) == 1) ? $urandom_range(0, 10) : $urandom_range(25, 35));
      r = $urandom();
      w = 24'(r) & 24'hFFFFFC;
      nxt = prev + 24'd4;
      if (i > 0 && $urandom_range(0, 1) == 1) w = nxt;
      if (i == 0 || gap >= 25) exp_lat = FRESH_LAT;
      else if (w == nxt && nxt != 24'd0) exp_lat = SEQ_LAT;
      else exp_lat = NONSEQ_LAT;
      repeat (gap) @(negedge HCLK);
      issue(w | 24'($urandom_range(0, 3)), lat, d);
      n_cmp++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rand_lat[%0d] addr=%h got=%0d exp=%0d", i, w, lat, exp_lat); end
      n_cmp++; if (d !== exp_word(w)) begin n_fail++; $display("FAIL rand_data[%0d] addr=%h got=%h exp=%h", i, w, d, exp_word(w)); end
      prev = w;
    end
    wait_idle();
  endtask

  task automatic test_pin_rules();
    n_cmp++; if (pin_err !== 0) begin n_fail++; $display("FAIL pin_rules got=%0d exp=0", pin_err); end
  endtask

  initial begin
    @(negedge HCLK);
    test_reset();
    test_single_read();
    test_hold_timeout();
    test_back_to_back();
    test_nonseq();
    test_wrap();
    test_reset_mid();
    test_random();
    test_pin_rules();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
